// File: rtl/pio_rx_fifo.sv
// rtl/pio_rx_fifo.sv - PIO receive FIFO with joinable depth and sticky stall/underflow flags
module pio_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pull,
    input  logic                         i_join,
    input  logic                         i_clear,
    input  logic                         i_clr_stall,
    input  logic                         i_clr_under,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(2*DEPTH):0]     o_level,
    output logic                         o_stall,
    output logic                         o_under
);
    localparam int PW = $clog2(2*DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] r_mem [2*DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_join;
    logic             r_stall;
    logic             r_under;

    logic [LW-1:0]    w_ed;
    logic [PW-1:0]    w_mask;
    logic             w_full;
    logic             w_empty;
    logic             w_flush;
    logic             w_push_ok;
    logic             w_pull_ok;
    logic             w_stall_set;
    logic             w_under_set;

    // Depth follows the registered join so full/empty depend on state only;
    // a join change flushes, so no transfer ever sees a mismatched depth.
    assign w_ed        = r_join ? LW'(2*DEPTH) : LW'(DEPTH);
    assign w_mask      = r_join ? PW'(2*DEPTH-1) : PW'(DEPTH-1);
    assign w_full      = (r_level == w_ed);
    assign w_empty     = (r_level == '0);
    assign w_flush     = i_clear | (i_join != r_join);
    assign w_push_ok   = i_push & ~w_full  & ~w_flush;
    assign w_pull_ok   = i_pull & ~w_empty & ~w_flush;
    assign w_stall_set = i_push &  w_full  & ~w_flush;
    assign w_under_set = i_pull &  w_empty & ~w_flush;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_join  <= 1'b0;
            r_stall <= 1'b0;
            r_under <= 1'b0;
        end else begin
            r_join  <= i_join;
            r_stall <= w_stall_set | (r_stall & ~i_clr_stall);
            r_under <= w_under_set | (r_under & ~i_clr_under);
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wptr <= (r_wptr + PW'(1)) & w_mask;
                end
                if (w_pull_ok) begin
                    r_rptr <= (r_rptr + PW'(1)) & w_mask;
                end
                case ({w_push_ok, w_pull_ok})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end
        end
    end

    assign o_dout  = w_empty ? '0 : r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;
    assign o_stall = r_stall;
    assign o_under = r_under;
endmodule
